// File: rtl/cordic_sched.sv
// Round-robin front end for a shared CORDIC vectoring pipeline: tags each issue, reorders nothing,
// and returns results through a credit-limited FWFT FIFO. Blanks after reset to flush stale results.
module cordic_sched #(
   parameter int unsigned WL    = 24,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LAT   = 21,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned TW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*WL-1:0] req_x,
   input  logic [NREQ*WL-1:0] req_y,
   output logic               cd_en,
   output logic [WL-1:0]      cd_x,
   output logic [WL-1:0]      cd_y,
   input  logic               cd_valid,
   input  logic [WL-1:0]      cd_mag,
   input  logic [23:0]        cd_phase,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [TW-1:0]      rsp_tag,
   output logic [WL-1:0]      rsp_mag,
   output logic [23:0]        rsp_phase,
   output logic               busy,
   output logic               err
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned BW = $clog2(LAT + 2);
   localparam int unsigned EW = TW + WL + 24;

   logic [TW-1:0]  ptr_q;
   logic [CW-1:0]  credit_q, credit_d;
   logic [BW-1:0]  blank_q;
   logic           cd_en_q;
   logic [WL-1:0]  cd_x_q, cd_y_q;
   logic [TW-1:0]  cd_tag_q;
   logic [LAT-1:0] tp_v_q;
   logic [TW-1:0]  tp_tag_q [LAT];
   logic [EW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [CW-1:0]  cnt_q;
   logic           err_q;

   logic          blank, can_grant, found, accept, push, pop, drop, miss;
   logic [TW-1:0] gnt_idx, idx;
   logic [EW-1:0] head;

   assign blank     = (blank_q != '0);
   assign can_grant = !blank && (credit_q < CW'(DEPTH));

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      found     = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      req_ready = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = TW'((int'(ptr_q) + k) % int'(NREQ));
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (found && can_grant) req_ready[gnt_idx] = 1'b1;
   end

   assign accept = |req_ready;
   assign push   = cd_valid && tp_v_q[LAT-1] && !blank;
   assign drop   = cd_valid && !tp_v_q[LAT-1] && !blank;
   assign miss   = tp_v_q[LAT-1] && !cd_valid;
   assign pop    = rsp_valid && rsp_ready;

   always_comb begin
      credit_d = credit_q;
      if (accept) credit_d = credit_d + CW'(1);
      if (pop)    credit_d = credit_d - CW'(1);
      if (miss)   credit_d = credit_d - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         credit_q <= '0;
         blank_q  <= BW'(LAT + 1);
         cd_en_q  <= 1'b0;
         cd_x_q   <= '0;
         cd_y_q   <= '0;
         cd_tag_q <= '0;
         err_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         cd_en_q  <= accept;
         err_q    <= err_q || drop || miss;
         if (blank) blank_q <= blank_q - BW'(1);
         if (accept) begin
            ptr_q    <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
            cd_x_q   <= req_x[int'(gnt_idx)*WL +: WL];
            cd_y_q   <= req_y[int'(gnt_idx)*WL +: WL];
            cd_tag_q <= gnt_idx;
         end
      end
   end

   // Tag pipe is fed alongside cd_en so its last stage lines up with cd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tp_v_q <= '0;
         for (int k = 0; k < int'(LAT); k++) tp_tag_q[k] <= '0;
      end else begin
         tp_v_q      <= {tp_v_q[LAT-2:0], cd_en_q};
         tp_tag_q[0] <= cd_tag_q;
         for (int k = 1; k < int'(LAT); k++) tp_tag_q[k] <= tp_tag_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
         if (pop)  rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (!push && pop) cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {tp_tag_q[LAT-1], cd_mag, cd_phase};
   end

   assign head      = mem_q[rptr_q];
   assign rsp_valid = (cnt_q != '0);
   // Gate the head so the outputs read zero whenever nothing is queued.
   assign rsp_tag   = rsp_valid ? head[EW-1 -: TW] : '0;
   assign rsp_mag   = rsp_valid ? head[24 +: WL] : '0;
   assign rsp_phase = rsp_valid ? head[23:0] : '0;

   assign cd_en = cd_en_q;
   assign cd_x  = cd_x_q;
   assign cd_y  = cd_y_q;
   assign err   = err_q;
   assign busy  = rst_n && ((credit_q != '0) || blank);

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched with a stand-in pipeline: mag = x + y, phase = x ^ y ^ 0x03243F.
module tb_cordic_sched;
   localparam int unsigned WL    = 24;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned LAT   = 21;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TW    = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*WL-1:0] req_x = '0;
   logic [NREQ*WL-1:0] req_y = '0;
   logic               cd_en;
   logic [WL-1:0]      cd_x, cd_y;
   logic               cd_valid;
   logic [WL-1:0]      cd_mag;
   logic [23:0]        cd_phase;
   logic               rsp_valid;
   logic               rsp_ready = 1'b1;
   logic [TW-1:0]      rsp_tag;
   logic [WL-1:0]      rsp_mag;
   logic [23:0]        rsp_phase;
   logic               busy, err;

   logic [LAT-1:0] pv = '0;
   logic [WL-1:0]  pm [LAT];
   logic [23:0]    pp [LAT];
   logic           inject = 1'b0;
   logic           suppress = 1'b0;

   typedef struct {
      logic [NREQ-1:0] valid;
      logic [NREQ-1:0] ready;
   } vec_t;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [WL-1:0] mag;
      logic [23:0]   phase;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   bit   saw_rsp = 1'b0;
   int   checks = 0;
   int   errors = 0;

   cordic_sched #(.WL(WL), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .cd_en     (cd_en),
      .cd_x      (cd_x),
      .cd_y      (cd_y),
      .cd_valid  (cd_valid),
      .cd_mag    (cd_mag),
      .cd_phase  (cd_phase),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_tag   (rsp_tag),
      .rsp_mag   (rsp_mag),
      .rsp_phase (rsp_phase),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Pipeline model keeps running through DUT reset, so stale results do appear.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], cd_en};
      pm[0] <= cd_x + cd_y;
      pp[0] <= cd_x ^ cd_y ^ 24'h03243F;
      for (int k = 1; k < int'(LAT); k++) begin
         pm[k] <= pm[k-1];
         pp[k] <= pp[k-1];
      end
   end

   assign cd_valid = (pv[LAT-1] && !suppress) || inject;
   assign cd_mag   = pm[LAT-1];
   assign cd_phase = pp[LAT-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: record accepts from the bench's own operands, check pops in order.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.tag   = TW'(i);
               e.mag   = req_x[i*WL +: WL] + req_y[i*WL +: WL];
               e.phase = req_x[i*WL +: WL] ^ req_y[i*WL +: WL] ^ 24'h03243F;
               sb.push_back(e);
            end
         end
         if (rsp_valid) saw_rsp = 1'b1;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_tag", 64'(rsp_tag), 64'(e.tag));
               chk("sb_mag", 64'(rsp_mag), 64'(e.mag));
               chk("sb_phase", 64'(rsp_phase), 64'(e.phase));
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops(input int c);
      for (int i = 0; i < int'(NREQ); i++) begin
         req_x[i*WL +: WL] = WL'((i + 1) << 16) + WL'(c);
         req_y[i*WL +: WL] = WL'((i + 1) << 12) + WL'(3 * c);
      end
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      rsp_ready = 1'b1;
      n = 0;
      while (busy && n < 200) begin
         nxt();
         n++;
      end
      chk("drain", 64'(busy), 64'd0);
   endtask

   task automatic count_blank();
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         nxt();
      end
      chk("blank_len", 64'(n), 64'd22);
   endtask

   // One lone request from requester r; checks issue and LAT+2 latency.
   task automatic issue_one(input int r);
      int n;
      logic [NREQ-1:0] m;
      logic [WL-1:0]   ex;
      m  = '0;
      m[r] = 1'b1;
      ex = req_x[r*WL +: WL];
      req_valid = m;
      #1;
      chk("one_grant", 64'(req_ready), 64'(m));
      nxt();
      req_valid = '0;
      chk("one_cd_en", 64'(cd_en), 64'd1);
      chk("one_cd_x", 64'(cd_x), 64'(ex));
      n = 1;
      nxt();
      n++;
      chk("one_cd_en_pulse", 64'(cd_en), 64'd0);
      while (!rsp_valid && n < 60) begin
         nxt();
         n++;
      end
      chk("one_latency", 64'(n), 64'd23);
      chk("one_tag", 64'(rsp_tag), 64'(r));
   endtask

   vec_t            tbl [10];
   logic [NREQ-1:0] exm;
   int              exp_ptr, grants, acc, multi, n;
   logic [63:0]     hold;

   initial begin
      tbl[0] = '{4'b1111, 4'b0001};
      tbl[1] = '{4'b1111, 4'b0010};
      tbl[2] = '{4'b0001, 4'b0001};
      tbl[3] = '{4'b0000, 4'b0000};
      tbl[4] = '{4'b1000, 4'b1000};
      tbl[5] = '{4'b0110, 4'b0010};
      tbl[6] = '{4'b0110, 4'b0100};
      tbl[7] = '{4'b0011, 4'b0001};
      tbl[8] = '{4'b1101, 4'b0100};
      tbl[9] = '{4'b1101, 4'b0000};  // credit exhausted after eight accepts

      // Reset state
      req_valid = '1;
      drive_ops(0);
      nxt();
      nxt();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_cd_en", 64'(cd_en), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("blank_nogrant", 64'(req_ready), 64'd0);
      req_valid = '0;
      count_blank();

      // Round-robin table
      for (int k = 0; k < 10; k++) begin
         req_valid = tbl[k].valid;
         drive_ops(k + 1);
         #1;
         chk($sformatf("tbl_%0d", k), 64'(req_ready), 64'(tbl[k].ready));
         nxt();
      end
      drain();

      // Requester 2 alone, operands 0x020000 / 0x020000
      req_x[2*WL +: WL] = 24'h020000;
      req_y[2*WL +: WL] = 24'h020000;
      issue_one(2);
      chk("s41_mag", 64'(rsp_mag), 64'h040000);
      chk("s41_phase", 64'(rsp_phase), 64'h03243F);
      nxt();
      drain();

      // All requesters continuously valid
      exp_ptr = 3;
      grants  = 0;
      req_valid = '1;
      for (int k = 0; k < 60; k++) begin
         drive_ops(100 + k);
         #1;
         if (k < 8 || req_ready != '0) begin
            exm = '0;
            exm[exp_ptr] = 1'b1;
            chk($sformatf("rr_order_%0d", k), 64'(req_ready), 64'(exm));
            exp_ptr = (exp_ptr + 1) % 4;
            grants++;
         end
         nxt();
      end
      chk("rr_grants", 64'(grants), 64'd24);
      drain();

      // Backpressure: credit caps accepts at DEPTH
      rsp_ready = 1'b0;
      req_valid = '1;
      acc   = 0;
      multi = 0;
      for (int k = 0; k < 40; k++) begin
         drive_ops(200 + k);
         #1;
         if (req_ready != '0) acc++;
         if ($countones(req_ready) > 1) multi++;
         nxt();
      end
      chk("bp_accepts", 64'(acc), 64'd8);
      chk("bp_multi", 64'(multi), 64'd0);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_head_valid", 64'(rsp_valid), 64'd1);
      hold = {16'h0, 6'h0, rsp_tag, rsp_mag};
      nxt();
      nxt();
      nxt();
      chk("bp_stable", {16'h0, 6'h0, rsp_tag, rsp_mag}, hold);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (req_ready != '0) acc++;
         nxt();
      end
      chk("bp_one_more", 64'(acc), 64'd1);
      chk("bp_err", 64'(err), 64'd0);
      drain();

      // Spurious cd_valid with an empty tag pipe
      drive_ops(300);
      req_valid = 4'b0001;
      #1;
      nxt();
      req_valid = '0;
      rsp_ready = 1'b0;
      n = 0;
      while (!rsp_valid && n < 60) begin
         nxt();
         n++;
      end
      chk("inj_head", 64'(rsp_valid), 64'd1);
      inject = 1'b1;
      nxt();
      inject = 1'b0;
      chk("inj_err", 64'(err), 64'd1);
      chk("inj_keep", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      nxt();
      chk("inj_count", 64'(rsp_valid), 64'd0);
      for (int k = 0; k < 5; k++) nxt();
      chk("err_sticky", 64'(err), 64'd1);
      chk("inj_idle", 64'(busy), 64'd0);

      // Reset with five results in flight
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         drive_ops(400 + k);
         nxt();
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) nxt();
      rst_n = 1'b0;
      req_valid = '1;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_cd_en", 64'(cd_en), 64'd0);
      chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_err", 64'(err), 64'd0);
      chk("mid_rst_mag", 64'(rsp_mag), 64'd0);
      sb.delete();
      nxt();
      nxt();
      rst_n = 1'b1;
      req_valid = '0;
      saw_rsp = 1'b0;
      #1;
      count_blank();
      for (int k = 0; k < 10; k++) nxt();
      chk("stale_err", 64'(err), 64'd0);
      chk("stale_rsp", 64'(saw_rsp), 64'd0);

      // Missing result: err set and credit returned
      suppress = 1'b1;
      drive_ops(500);
      req_valid = 4'b0010;
      #1;
      chk("miss_grant", 64'(req_ready), 64'b0010);
      nxt();
      req_valid = '0;
      saw_rsp = 1'b0;
      n = 0;
      while (busy && n < 80) begin
         nxt();
         n++;
      end
      chk("miss_credit", 64'(busy), 64'd0);
      chk("miss_err", 64'(err), 64'd1);
      chk("miss_rsp", 64'(saw_rsp), 64'd0);
      suppress = 1'b0;
      sb.delete();
      drive_ops(600);
      issue_one(3);
      nxt();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
